// File: rtl/frame_buffer_dbuf.sv
// Double-buffered monochrome frame buffer. It maps VGA scan coordinates to pixels
// through a three-stage pipeline, and page swaps take effect only at frame start.
module frame_buffer_dbuf #(
  parameter int SCREEN_W   = 512,
  parameter int SCREEN_H   = 256,
  parameter int VGA_W      = 800,
  parameter int VGA_H      = 480,
  parameter int WORD_W     = 16,
  parameter int COORD_W    = 11,
  parameter int ADDR_W     = 13,
  parameter int DOUBLE_BUF = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  write_address,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               load,
  input  logic               swap_req,
  input  logic [COORD_W-1:0] vga_h,
  input  logic [COORD_W-1:0] vga_v,
  input  logic               vga_active,
  input  logic               invert,
  input  logic               border_pixel,
  output logic               pixel_out,
  output logic               pixel_valid,
  output logic               display_page,
  output logic               swap_pending
);

  localparam int DEPTH  = SCREEN_W * SCREEN_H / WORD_W;
  localparam int H_OFF  = (VGA_W - SCREEN_W) / 2;
  localparam int V_OFF  = (VGA_H - SCREEN_H) / 2;
  localparam int PAGES  = (DOUBLE_BUF != 0) ? 2 : 1;
  localparam int RAM_AW = (PAGES * DEPTH > 1) ? $clog2(PAGES * DEPTH) : 1;
  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] mem [PAGES*DEPTH];
  logic [WORD_W-1:0] rd_data;

  logic              frame_start;
  logic              do_swap;
  logic              page_next;
  logic              pending_next;
  logic              rd_page;
  logic              wr_page;
  logic              wr_en;
  logic [RAM_AW-1:0] wr_idx;
  logic [RAM_AW-1:0] rd_idx;
  logic              in_win;
  logic [BIT_W-1:0]  bit_idx;
  int                h_rel;
  int                v_rel;
  int                word_lin;

  // Stage 1 pipeline registers
  logic              in_win_s1;
  logic              active_s1;
  logic [BIT_W-1:0]  bit_s1;
  logic              invert_s1;
  logic              border_s1;
  logic [RAM_AW-1:0] rd_idx_s1;

  // Stage 2 side-band, travelling alongside the RAM read
  logic              in_win_s2;
  logic              active_s2;
  logic [BIT_W-1:0]  bit_s2;
  logic              invert_s2;
  logic              border_s2;

  always_comb begin
    frame_start = (vga_h == '0) && (vga_v == '0);
    do_swap     = (DOUBLE_BUF != 0) && frame_start && (swap_pending || swap_req);
    page_next   = display_page ^ do_swap;
    if (DOUBLE_BUF == 0) begin
      pending_next = 1'b0;
    end else if (do_swap) begin
      pending_next = 1'b0;
    end else begin
      pending_next = swap_pending | swap_req;
    end
  end

  // Reads follow the post-swap page, so the frame-start pixel already shows the new page.
  always_comb begin
    h_rel    = int'(vga_h) - H_OFF;
    v_rel    = int'(vga_v) - V_OFF;
    in_win   = (h_rel >= 0) && (h_rel < SCREEN_W) && (v_rel >= 0) && (v_rel < SCREEN_H);
    word_lin = in_win ? (v_rel * SCREEN_W + h_rel) / WORD_W : 0;
    bit_idx  = in_win ? BIT_W'(h_rel % WORD_W) : '0;
    rd_page  = (DOUBLE_BUF != 0) ? page_next : 1'b0;
    rd_idx   = RAM_AW'(int'(rd_page) * DEPTH + word_lin);
  end

  // Writes target the back page as seen before any swap on this edge.
  always_comb begin
    wr_page = (DOUBLE_BUF != 0) ? ~display_page : 1'b0;
    wr_en   = load && (int'(write_address) < DEPTH);
    wr_idx  = RAM_AW'(int'(wr_page) * DEPTH + int'(write_address));
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= data_in;
    end
    rd_data <= mem[rd_idx_s1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_page <= 1'b0;
      swap_pending <= 1'b0;
      in_win_s1    <= 1'b0;
      active_s1    <= 1'b0;
      bit_s1       <= '0;
      invert_s1    <= 1'b0;
      border_s1    <= 1'b0;
      rd_idx_s1    <= '0;
      in_win_s2    <= 1'b0;
      active_s2    <= 1'b0;
      bit_s2       <= '0;
      invert_s2    <= 1'b0;
      border_s2    <= 1'b0;
      pixel_out    <= 1'b0;
      pixel_valid  <= 1'b0;
    end else begin
      display_page <= (DOUBLE_BUF != 0) ? page_next : 1'b0;
      swap_pending <= pending_next;

      in_win_s1    <= in_win;
      active_s1    <= vga_active;
      bit_s1       <= bit_idx;
      invert_s1    <= invert;
      border_s1    <= border_pixel;
      rd_idx_s1    <= rd_idx;

      in_win_s2    <= in_win_s1;
      active_s2    <= active_s1;
      bit_s2       <= bit_s1;
      invert_s2    <= invert_s1;
      border_s2    <= border_s1;

      pixel_valid  <= active_s2;
      pixel_out    <= active_s2 & (in_win_s2 ? (rd_data[bit_s2] ^ invert_s2) : border_s2);
    end
  end

endmodule

// File: tb/tb_frame_buffer_dbuf.sv
// Directed bench for frame_buffer_dbuf: a page/pixel model checked every cycle,
// plus literal expectations at the interesting coordinates.
module tb_frame_buffer_dbuf;

  localparam int SW    = 512;
  localparam int SH    = 256;
  localparam int WW    = 16;
  localparam int DEPTH = SW * SH / WW;
  localparam int HO    = 144;
  localparam int VO    = 112;
  localparam int AW    = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [15:0]   data_in = '0;
  logic          load = 1'b0;
  logic          swap_req = 1'b0;
  logic [10:0]   vga_h = '0;
  logic [10:0]   vga_v = '0;
  logic          vga_active = 1'b0;
  logic          invert = 1'b0;
  logic          border_pixel = 1'b0;
  logic          pixel_out;
  logic          pixel_valid;
  logic          display_page;
  logic          swap_pending;

  always #5 clk = ~clk;

  frame_buffer_dbuf #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .write_address(write_address), .data_in(data_in),
    .load(load), .swap_req(swap_req), .vga_h(vga_h), .vga_v(vga_v),
    .vga_active(vga_active), .invert(invert), .border_pixel(border_pixel),
    .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .display_page(display_page), .swap_pending(swap_pending)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: pages of words, with a flag marking words the bench has written.
  typedef struct packed {bit valid; bit pix; bit known;} exp_t;
  bit [15:0] mem_m   [2][DEPTH];
  bit        known_m [2][DEPTH];
  bit        page_m = 1'b0;
  bit        pend_m = 1'b0;
  exp_t      p1 = 3'b001;
  exp_t      p2 = 3'b001;
  exp_t      out_e = 3'b001;

  initial begin : model
    int   hh, vv, idx, w, b;
    bit   old;
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        page_m = 1'b0;
        pend_m = 1'b0;
        p1 = 3'b001;
        p2 = 3'b001;
        out_e = 3'b001;
      end else begin
        old = page_m;
        if (vga_h == 0 && vga_v == 0 && (pend_m || swap_req)) begin
          page_m = !page_m;
          pend_m = 1'b0;
        end else if (swap_req) begin
          pend_m = 1'b1;
        end
        if (load && write_address < DEPTH) begin
          mem_m[!old][write_address]   = data_in;
          known_m[!old][write_address] = 1'b1;
        end
        e  = 3'b001;
        hh = int'(vga_h) - HO;
        vv = int'(vga_v) - VO;
        if (vga_active) begin
          if (hh >= 0 && hh < SW && vv >= 0 && vv < SH) begin
            idx = vv * SW + hh;
            w   = idx / WW;
            b   = idx % WW;
            e.valid = 1'b1;
            e.pix   = mem_m[page_m][w][b] ^ invert;
            e.known = known_m[page_m][w];
          end else begin
            e.valid = 1'b1;
            e.pix   = border_pixel;
          end
        end
        out_e = p2;
        p2 = p1;
        p1 = e;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("cyc_valid", pixel_valid, out_e.valid);
      if (out_e.known) chk("cyc_pixel", pixel_out, out_e.pix);
      chk("cyc_page", display_page, page_m);
      chk("cyc_pending", swap_pending, pend_m);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int h, input int v, input bit act);
    vga_h = 11'(h);
    vga_v = 11'(v);
    vga_active = act;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    write_address = a;
    data_in = d;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic probe(input string name, input int h, input int v, input bit act,
                       input bit ex_px, input bit ex_val);
    set_xy(h, v, act);
    repeat (3) step();
    chk({name, "_px"}, pixel_out, ex_px);
    chk({name, "_valid"}, pixel_valid, ex_val);
  endtask

  initial begin : stim
    repeat (3) step();
    chk("rst_px", pixel_out, 0);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_page", display_page, 0);
    chk("rst_pend", swap_pending, 0);
    rst_n = 1'b1;

    set_xy(10, 10, 1);
    wr(0, 16'h0001);
    wr(5, 16'h8000);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("pend_set", swap_pending, 1);
    chk("page_before", display_page, 0);
    step();
    chk("pend_hold", swap_pending, 1);
    set_xy(0, 0, 1);
    step();
    chk("page_toggle", display_page, 1);
    chk("pend_clear", swap_pending, 0);
    set_xy(1, 0, 1);
    step();

    probe("first", 144, 112, 1, 1, 1);
    probe("second", 145, 112, 1, 0, 1);
    probe("bit15", 144 + 95, 112, 1, 1, 1);
    probe("bit0", 144 + 80, 112, 1, 0, 1);

    border_pixel = 1'b1;
    probe("border_l", 143, 112, 1, 1, 1);
    probe("border_r", 656, 112, 1, 1, 1);
    probe("border_t", 144, 111, 1, 1, 1);
    probe("border_b", 144, 368, 1, 1, 1);
    probe("inactive", 144, 112, 0, 0, 0);
    probe("inactive_brd", 143, 112, 0, 0, 0);

    set_xy(10, 10, 1);
    wr(0, 16'h0002);
    wr(14'd8192, 16'hFFFF);
    probe("range_b0", 144, 112, 1, 1, 1);
    probe("range_b1", 145, 112, 1, 0, 1);

    invert = 1'b1;
    probe("inv_b0", 144, 112, 1, 0, 1);
    probe("inv_b1", 145, 112, 1, 1, 1);
    probe("inv_border", 143, 112, 1, 1, 1);
    invert = 1'b0;

    set_xy(0, 0, 1);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("coinc_page", display_page, 0);
    chk("coinc_pend", swap_pending, 0);
    set_xy(1, 0, 1);
    step();
    probe("pg0_b0", 144, 112, 1, 0, 1);
    probe("pg0_b1", 145, 112, 1, 1, 1);

    set_xy(20, 3, 1);
    swap_req = 1'b1;
    step();
    step();
    swap_req = 1'b0;
    step();
    chk("dbl_pend", swap_pending, 1);
    chk("dbl_page_hold", display_page, 0);
    set_xy(0, 0, 1);
    step();
    chk("dbl_page", display_page, 1);
    chk("dbl_pend_clr", swap_pending, 0);
    set_xy(1, 0, 1);
    step();
    set_xy(0, 0, 1);
    step();
    chk("dbl_single", display_page, 1);
    set_xy(1, 0, 1);
    step();

    set_xy(144, 112, 1);
    repeat (4) step();
    chk("pre_rst_px", pixel_out, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_px", pixel_out, 0);
    chk("async_valid", pixel_valid, 0);
    chk("async_page", display_page, 0);
    chk("async_pend", swap_pending, 0);
    repeat (2) step();
    rst_n = 1'b1;
    probe("post_b0", 144, 112, 1, 0, 1);
    probe("post_b1", 145, 112, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
